// File: rtl/uart_mmio_ctrl_if.sv
// CPU I/O-region bus plus UART byte handshakes for uart_mmio_ctrl.
// master = CPU/UART side driving the controller, slave = the controller itself.
interface uart_mmio_ctrl_if;
    logic        stall;
    logic [4:0]  io_addr;
    logic        io_re;
    logic        io_we;
    logic [7:0]  io_wdata;
    logic [31:0] io_rdata;
    logic [7:0]  uart_din;
    logic        uart_din_valid;
    logic        uart_din_ready;
    logic [7:0]  uart_dout;
    logic        uart_dout_valid;
    logic        uart_dout_ready;

    modport master (
        output stall, io_addr, io_re, io_we, io_wdata, uart_din_ready, uart_dout,
               uart_dout_valid,
        input  io_rdata, uart_din, uart_din_valid, uart_dout_ready
    );

    modport slave (
        input  stall, io_addr, io_re, io_we, io_wdata, uart_din_ready, uart_dout,
               uart_dout_valid,
        output io_rdata, uart_din, uart_din_valid, uart_dout_ready
    );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// MMIO bridge between the MIPS150 memory stage and the UART byte interface.
// Define UART_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO; otherwise RX holds one byte.
module uart_mmio_ctrl #(
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned CNT_W    = 32
) (
    input logic             clk,
    input logic             rst,
    uart_mmio_ctrl_if.slave bus
);

    localparam logic [2:0] AddrRxCtrl   = 3'd0;
    localparam logic [2:0] AddrRxData   = 3'd1;
    localparam logic [2:0] AddrTxCtrl   = 3'd2;
    localparam logic [2:0] AddrTxData   = 3'd3;
    localparam logic [2:0] AddrCycle    = 3'd4;
    localparam logic [2:0] AddrCycleClr = 3'd6;
    localparam int unsigned unusedDepth = RX_DEPTH;

    logic [2:0] sel;
    logic       cpuRe, cpuWe;
    logic       unusedAddr;

    assign sel        = bus.io_addr[4:2];
    assign cpuRe      = bus.io_re & ~bus.stall;
    assign cpuWe      = bus.io_we & ~bus.stall;
    assign unusedAddr = ^bus.io_addr[1:0];

    // RX storage
    logic       rxFull, rxNonEmpty, rxPush, rxPop;
    logic [7:0] rxHead;

    assign rxPush              = bus.uart_dout_valid & ~rxFull;
    assign rxPop               = cpuRe & (sel == AddrRxData) & rxNonEmpty;
    assign bus.uart_dout_ready = ~rxFull;

`ifdef UART_RX_FIFO_EN
    localparam int unsigned PtrW = $clog2(RX_DEPTH);

    logic [7:0]      rxMem [RX_DEPTH];
    logic [PtrW-1:0] wrPtrQ, rdPtrQ;
    logic [PtrW:0]   countQ;

    assign rxFull     = countQ == (PtrW + 1)'(RX_DEPTH);
    assign rxNonEmpty = countQ != '0;
    assign rxHead     = rxMem[rdPtrQ];

    always_ff @(posedge clk) begin
        if (rxPush) rxMem[wrPtrQ] <= bus.uart_dout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (rxPush) wrPtrQ <= wrPtrQ + PtrW'(1);
            if (rxPop)  rdPtrQ <= rdPtrQ + PtrW'(1);
            case ({rxPush, rxPop})
                2'b10:   countQ <= countQ + (PtrW + 1)'(1);
                2'b01:   countQ <= countQ - (PtrW + 1)'(1);
                default: countQ <= countQ;
            endcase
        end
    end
`else
    logic [7:0] rxDataQ;
    logic       rxValidQ;

    assign rxFull     = rxValidQ;
    assign rxNonEmpty = rxValidQ;
    assign rxHead     = rxDataQ;

    // Push needs !valid and pop needs valid, so they never coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxDataQ  <= '0;
            rxValidQ <= 1'b0;
        end else if (rxPush) begin
            rxDataQ  <= bus.uart_dout;
            rxValidQ <= 1'b1;
        end else if (rxPop) begin
            rxValidQ <= 1'b0;
        end
    end
`endif

    // TX holding register, cycle counter and read data
    logic             txFullQ, txFullD, txOverrunQ, txOverrunD, txHs, txWr, cycleClr;
    logic [7:0]       txDataQ, txDataD;
    logic [CNT_W-1:0] cycleQ, cycleD;
    logic [31:0]      rdataQ, rdataD;

    assign txHs     = txFullQ & bus.uart_din_ready;
    assign txWr     = cpuWe & (sel == AddrTxData);
    assign cycleClr = cpuWe & (sel == AddrCycleClr);

    always_comb begin
        txFullD    = txFullQ;
        txDataD    = txDataQ;
        txOverrunD = txOverrunQ;
        if (cpuRe && sel == AddrTxCtrl) txOverrunD = 1'b0;
        // A handshake in the same cycle frees the slot, so the write lands.
        if (txWr && (!txFullQ || txHs)) begin
            txFullD = 1'b1;
            txDataD = bus.io_wdata;
        end else begin
            if (txHs) txFullD = 1'b0;
            if (txWr) txOverrunD = 1'b1;
        end
    end

    assign cycleD = cycleClr ? '0 : cycleQ + CNT_W'(1);

    always_comb begin
        rdataD = rdataQ;
        if (cpuRe) begin
            rdataD = '0;
            case (sel)
                AddrRxCtrl: rdataD[0]   = rxNonEmpty;
                AddrRxData: rdataD[7:0] = rxNonEmpty ? rxHead : 8'h00;
                AddrTxCtrl: rdataD[1:0] = {txOverrunQ, ~txFullQ};
                AddrCycle:  rdataD      = 32'(cycleQ);
                default:    rdataD      = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txFullQ    <= 1'b0;
            txDataQ    <= '0;
            txOverrunQ <= 1'b0;
            cycleQ     <= '0;
            rdataQ     <= '0;
        end else begin
            txFullQ    <= txFullD;
            txDataQ    <= txDataD;
            txOverrunQ <= txOverrunD;
            cycleQ     <= cycleD;
            rdataQ     <= rdataD;
        end
    end

    assign bus.uart_din       = txDataQ;
    assign bus.uart_din_valid = txFullQ;
    assign bus.io_rdata       = rdataQ;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl: reads push expected data, a monitor pops and compares.
// Expectations follow UART_RX_FIFO_EN (depth 4) or the single-byte RX register.
module tb_uart_mmio_ctrl;

    localparam logic [4:0] ARxCtrl   = 5'h00;
    localparam logic [4:0] ARxData   = 5'h04;
    localparam logic [4:0] ATxCtrl   = 5'h08;
    localparam logic [4:0] ATxData   = 5'h0C;
    localparam logic [4:0] ACycle    = 5'h10;
    localparam logic [4:0] AHole     = 5'h14;
    localparam logic [4:0] ACycleClr = 5'h18;
    localparam logic [4:0] AHole2    = 5'h1C;
`ifdef UART_RX_FIFO_EN
    localparam int Depth = 4;
`else
    localparam int Depth = 1;
`endif

    typedef struct {
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t expQ[$];

    uart_mmio_ctrl_if bus();

    uart_mmio_ctrl #(
        .RX_DEPTH(4),
        .CNT_W   (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Posedges since reset release, i.e. the counter value seen by the next edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: any unstalled load edge must match the oldest queued expectation.
    always begin
        @(posedge clk);
        if (rst && bus.io_re && !bus.stall) begin
            @(negedge clk);
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got %h want no read", bus.io_rdata);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                check(e.name, bus.io_rdata, e.val);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] e);
        exp_t x;
        x.val = e;
        x.name = name;
        expQ.push_back(x);
        bus.io_addr = a;
        bus.io_re   = 1'b1;
        @(negedge clk);
        bus.io_re   = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus.io_addr  = a;
        bus.io_wdata = d;
        bus.io_we    = 1'b1;
        @(negedge clk);
        bus.io_we    = 1'b0;
    endtask

    task automatic sendRx(input logic [7:0] b);
        bus.uart_dout       = b;
        bus.uart_dout_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.uart_dout_ready) begin
                @(negedge clk);
                bus.uart_dout_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.uart_dout_valid = 1'b0;
        total++;
        bad++;
        $display("FAIL rx_send_timeout: got ready=0 for 50 cycles want ready=1");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rxB[3];
        logic [7:0] w[Depth+1];
        rxB[0] = 8'hA5;
        rxB[1] = 8'h5A;
        rxB[2] = 8'h3C;
        bus.stall = 1'b0;
        bus.io_addr = '0;
        bus.io_re = 1'b0;
        bus.io_we = 1'b0;
        bus.io_wdata = '0;
        bus.uart_din_ready = 1'b0;
        bus.uart_dout = '0;
        bus.uart_dout_valid = 1'b0;
        idle(2);
        rst = 1'b1;

        // Reset state
        check("rst_rdata", bus.io_rdata, 32'h0);
        check("rst_din", {24'h0, bus.uart_din}, 32'h0);
        check("rst_din_valid", {31'h0, bus.uart_din_valid}, 32'h0);
        check("rst_dout_ready", {31'h0, bus.uart_dout_ready}, 32'h1);
        rd("rst_txctrl", ATxCtrl, 32'h1);
        rd("rst_rxctrl", ARxCtrl, 32'h0);

        // Single TX byte
        wr(ATxData, 8'h41);
        check("tx_din", {24'h0, bus.uart_din}, 32'h41);
        check("tx_valid", {31'h0, bus.uart_din_valid}, 32'h1);
        bus.uart_din_ready = 1'b1;
        idle(1);
        bus.uart_din_ready = 1'b0;
        check("tx_valid_after_hs", {31'h0, bus.uart_din_valid}, 32'h0);
        rd("tx_ctrl_empty", ATxCtrl, 32'h1);

        // Overrun while full, then sticky clear on read
        wr(ATxData, 8'h10);
        wr(ATxData, 8'h11);
        check("ovr_din_held", {24'h0, bus.uart_din}, 32'h10);
        check("ovr_valid", {31'h0, bus.uart_din_valid}, 32'h1);
        rd("ovr_txctrl", ATxCtrl, 32'h2);
        rd("ovr_txctrl_cleared", ATxCtrl, 32'h0);
        // Write coinciding with the handshake reloads instead of overrunning
        bus.uart_din_ready = 1'b1;
        wr(ATxData, 8'h22);
        bus.uart_din_ready = 1'b0;
        check("reload_din", {24'h0, bus.uart_din}, 32'h22);
        check("reload_valid", {31'h0, bus.uart_din_valid}, 32'h1);
        rd("reload_txctrl", ATxCtrl, 32'h0);
        bus.uart_din_ready = 1'b1;
        idle(1);
        bus.uart_din_ready = 1'b0;
        rd("drain_txctrl", ATxCtrl, 32'h1);

        // RX ordering
`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 3; i++) sendRx(rxB[i]);
        rd("rx_ctrl_nonempty", ARxCtrl, 32'h1);
        for (int i = 0; i < 3; i++) rd("rx_data_order", ARxData, {24'h0, rxB[i]});
`else
        for (int i = 0; i < 3; i++) begin
            sendRx(rxB[i]);
            rd("rx_ctrl_nonempty", ARxCtrl, 32'h1);
            rd("rx_data_order", ARxData, {24'h0, rxB[i]});
        end
`endif
        rd("rx_ctrl_empty", ARxCtrl, 32'h0);
        rd("rx_data_empty", ARxData, 32'h0);

        // Fill, back-pressure, pop and accept across pointer wrap
        for (int i = 0; i <= Depth; i++) w[i] = 8'hB0 + 8'(i);
        for (int i = 0; i < Depth; i++) sendRx(w[i]);
        check("full_ready_low", {31'h0, bus.uart_dout_ready}, 32'h0);
        bus.uart_dout = w[Depth];
        bus.uart_dout_valid = 1'b1;
        idle(2);
        check("held_off_ready_low", {31'h0, bus.uart_dout_ready}, 32'h0);
        rd("wrap_first", ARxData, {24'h0, w[0]});
        check("ready_after_pop", {31'h0, bus.uart_dout_ready}, 32'h1);
        idle(1);
        bus.uart_dout_valid = 1'b0;
        check("refull_ready_low", {31'h0, bus.uart_dout_ready}, 32'h0);
        for (int i = 1; i <= Depth; i++) rd("wrap_order", ARxData, {24'h0, w[i]});
        rd("wrap_empty", ARxCtrl, 32'h0);

        // Cycle counter and clear
        rd("cycle_known", ACycle, 32'(cyc));
        wr(ACycleClr, 8'h00);
        idle(2);
        rd("cycle_after_clr", ACycle, 32'd2);
        rd("cycle_next", ACycle, 32'd3);

        // Unmapped offsets
        wr(AHole2, 8'hFF);
        rd("hole_read", AHole, 32'h0);
        rd("hole2_read", AHole2, 32'h0);

        // Stalled load has no side effects
        sendRx(8'h77);
        rd("stall_pre", ARxCtrl, 32'h1);
        bus.stall = 1'b1;
        bus.io_addr = ARxData;
        bus.io_re = 1'b1;
        idle(1);
        bus.io_re = 1'b0;
        bus.stall = 1'b0;
        check("stall_rdata_held", bus.io_rdata, 32'h1);
        rd("stall_no_pop", ARxCtrl, 32'h1);
        rd("stall_data", ARxData, 32'h77);

        // Load and store strobed together
        begin
            exp_t x;
            x.val = 32'h0;
            x.name = "re_we_read";
            expQ.push_back(x);
        end
        bus.io_addr = ATxData;
        bus.io_wdata = 8'h66;
        bus.io_re = 1'b1;
        bus.io_we = 1'b1;
        idle(1);
        bus.io_re = 1'b0;
        bus.io_we = 1'b0;
        check("re_we_din", {24'h0, bus.uart_din}, 32'h66);
        check("re_we_valid", {31'h0, bus.uart_din_valid}, 32'h1);

        // Asynchronous reset mid-transfer
        sendRx(8'h99);
        rd("pre_rst_rx", ARxCtrl, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", {31'h0, bus.uart_din_valid}, 32'h0);
        check("arst_din", {24'h0, bus.uart_din}, 32'h0);
        check("arst_rdata", bus.io_rdata, 32'h0);
        check("arst_dout_ready", {31'h0, bus.uart_dout_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        rd("post_rst_rxctrl", ARxCtrl, 32'h0);
        rd("post_rst_rxdata", ARxData, 32'h0);
        rd("post_rst_txctrl", ATxCtrl, 32'h1);

        idle(2);
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("FAIL pending_reads: got %0d outstanding want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
